ex_issue_ctrl: RTL
==================

// Module: ex_issue_ctrl
// PURPOSE
// Execute-stage issue controller that sits directly upstream of the RV32IM ALU.
// - Accepts one decoded instruction per handshake from decode.
// - Maps funct3/funct7/class to the ALU 5-bit sel code and drives the ALU operands.
// - Holds operands stable while multi-cycle MUL/DIV runs, then registers the result for writeback.
// - Only one operation is in flight at a time. Single-cycle ops sustain 1 op/cycle.
// PARAMETERS
// XLEN         32   operand/result width
// MIN_MD_WAIT  1    cycles after MUL/DIV issue during which alu_ready is ignored (stale done)
// MD_TIMEOUT   64   cycles in WAIT_MD before abort with md_timeout=1; 0 disables the check
// PORTS
// clk          in   1     clock, all logic on rising edge
// rst          in   1     synchronous reset, active-low (rst==0 resets)
// in_valid     in   1     decode offers an instruction
// in_ready     out  1     controller can accept this cycle
// in_class     in   2     0=OP (reg-reg), 1=OP-IMM, 2=MULDIV, 3=illegal
// in_funct3    in   3     instruction funct3
// in_funct7b5  in   1     funct7[5]: SUB/SRA select
// in_rs1       in   XLEN  rs1 value
// in_rs2       in   XLEN  rs2 value
// in_imm       in   XLEN  sign-extended immediate
// in_rd        in   5     destination register
// alu_dataA    out  XLEN  ALU operand A
// alu_dataB    out  XLEN  ALU operand B
// alu_sel      out  5     ALU opcode
// alu_dataD    in   XLEN  ALU result
// alu_ready    in   1     ALU result valid (1 for non-MULDIV)
// out_valid    out  1     registered result available
// out_ready    in   1     writeback accepts the result
// out_data     out  XLEN  result
// out_rd       out  5     destination register
// out_illegal  out  1     op was illegal; out_data=0
// md_timeout   out  1     MUL/DIV aborted by timeout; out_data=32'hDEADBEEF
// BEHAVIOUR
// - Reset: state=IDLE; out_valid, out_illegal, md_timeout = 0; out_data=0, out_rd=0; alu_sel=5'h00; alu_dataA/B=0.
// - Handshakes: a transfer occurs when valid&&ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
//   out_* holds stable while out_valid && !out_ready.
// - Sel map, OP/OP-IMM (funct3 -> sel):
//   000: OP&&b5 ? 08 (SUB) : 00 (ADD); OP-IMM never SUB
//   001: 01    010: 02    011: 03    100: 04
//   101: b5 ? 0D (SRA) : 05
//   110: 06    111: 07
// - Sel map, MULDIV (funct3 -> sel): 000 1E, 001 1F, 010 19, 011 18, 100 12, 101 13, 110 14, 111 15.
// - Operand B is in_imm for OP-IMM and in_rs2 otherwise. Shift amounts use B[4:0] only (ALU-side).
// - FSM states:
//   IDLE    Accept; drive ALU combinationally from inputs.
//           Single-cycle op: out_* <= alu_dataD next edge, stay IDLE (latency 1).
//           MULDIV: latch operands/sel, go WAIT_MD.
//           Illegal: out_valid=1, out_illegal=1, no ALU use.
//   WAIT_MD Drive latched operands/sel unchanged; count cycles.
//           alu_ready is ignored for the first MIN_MD_WAIT cycles.
//           On alu_ready: out_* <= alu_dataD, go DRAIN.
//           On count==MD_TIMEOUT: out_data=DEADBEEF, md_timeout=1, go DRAIN.
//   DRAIN   One cycle with alu_sel=00 and operands 0, so the MUL/DIV units observe an op change.
//           Then IDLE. Back-to-back MULDIV therefore costs >=1 bubble.
// - MUL/DIV latency = ALU latency + 1 (register) + 1 (DRAIN) before the next accept.
// - Boundary: out_ready low in IDLE blocks accept (no overwrite).
//   WAIT_MD completion with out_valid still high stalls in WAIT_MD holding operands.
//   Div-by-zero/overflow semantics are owned by the ALU and passed through unmodified.
// - Reset mid-WAIT_MD: abandon the op, all outputs to reset values next edge, no out_valid pulse.
// STRUCTURE
// - Package ex_pkg:
//   alu_sel_e enum (all 22 ALU codes), op_class_e, state_e {IDLE, WAIT_MD, DRAIN}, ALU_SEL_DEBUG=32'hDEADBEEF.
// - One sub-module: ex_sel_decode (combinational class/funct3/funct7b5 -> alu_sel, is_muldiv, illegal).
// - FSM, timeout counter, and output register live in ex_issue_ctrl.
// TESTING
// - OP ADD rs1=5 rs2=7, out_ready=1 -> out_valid next cycle, out_data=12, in_ready stays 1.
// - OP-IMM funct3=000 b5=1, rs1=10 imm=3 -> ADD (sel 00) result 13, never SUB.
//   OP funct3=101 b5=1 rs1=0x80000000 rs2=4 -> sel 0D driven.
// - MUL rs1=-3 rs2=4, ALU ready after 17 cycles -> in_ready=0 throughout, operands stable, out_data=0xFFFFFFF4, one DRAIN cycle with sel=00.
// - Result pending with out_ready=0 for 5 cycles, new in_valid -> no accept, out_data unchanged; accept on the cycle after out_ready=1.
// - alu_ready stuck 0, MD_TIMEOUT=64 -> md_timeout=1, out_data=DEADBEEF at cycle 64.
//   Separately, rst=0 at WAIT_MD cycle 3 -> no out_valid, all outputs at reset values.
// - in_class=3 -> out_illegal=1, out_data=0, alu_sel stays 00.

Source files
------------

// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared types for the execute-stage issue controller: the ALU opcode
// encoding, the decoded instruction class, the issue FSM states and the
// marker value returned when a MUL/DIV operation is abandoned.
// No ports (package).
// ---------------------------------------------------------------------------
package ex_pkg;

  // ALU opcode space. Integer ops occupy the low codes; MUL/DIV ops sit in
  // the upper half so the ALU can tell single-cycle work from multi-cycle work.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SLL    = 5'h01,
    ALU_SLT    = 5'h02,
    ALU_SLTU   = 5'h03,
    ALU_XOR    = 5'h04,
    ALU_SRL    = 5'h05,
    ALU_OR     = 5'h06,
    ALU_AND    = 5'h07,
    ALU_SUB    = 5'h08,
    ALU_EQ     = 5'h09,
    ALU_NE     = 5'h0A,
    ALU_GE     = 5'h0B,
    ALU_GEU    = 5'h0C,
    ALU_SRA    = 5'h0D,
    ALU_DIV    = 5'h12,
    ALU_DIVU   = 5'h13,
    ALU_REM    = 5'h14,
    ALU_REMU   = 5'h15,
    ALU_MULHU  = 5'h18,
    ALU_MULHSU = 5'h19,
    ALU_MUL    = 5'h1E,
    ALU_MULH   = 5'h1F
  } alu_sel_e;

  // Instruction class as delivered by decode.
  typedef enum logic [1:0] {
    CLS_OP      = 2'd0,
    CLS_OPIMM   = 2'd1,
    CLS_MULDIV  = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  // Issue FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_MD = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Result reported when a MUL/DIV never completes.
  localparam logic [31:0] ALU_SEL_DEBUG = 32'hDEADBEEF;

endpackage

// File: rtl/ex_sel_decode.sv
// ---------------------------------------------------------------------------
// ex_sel_decode
// Purely combinational translation of the decoded instruction class and
// function bits into the ALU opcode, plus flags telling the issue FSM whether
// the operation is multi-cycle or illegal.
// Ports:
//   i_class     in  2  instruction class (op_class_e encoding)
//   i_funct3    in  3  instruction funct3
//   i_funct7b5  in  1  funct7[5], selects SUB / SRA
//   o_sel       out 5  ALU opcode (ADD for illegal)
//   o_isMuldiv  out 1  operation runs on the multi-cycle MUL/DIV units
//   o_illegal   out 1  class is illegal, no ALU use
// ---------------------------------------------------------------------------
module ex_sel_decode
  import ex_pkg::*;
(
  input  logic [1:0] i_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [4:0] o_sel,
  output logic       o_isMuldiv,
  output logic       o_illegal
);

  alu_sel_e w_sel;

  // funct7[5] only means SUB for register-register ops; an OP-IMM with that
  // bit set in funct3=000 is still ADDI. SRA/SRAI both honour the bit.
  always_comb begin
    w_sel      = ALU_ADD;
    o_isMuldiv = 1'b0;
    o_illegal  = 1'b0;
    case (op_class_e'(i_class))
      CLS_OP, CLS_OPIMM: begin
        case (i_funct3)
          3'b000: w_sel = ((op_class_e'(i_class) == CLS_OP) && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: w_sel = ALU_SLL;
          3'b010: w_sel = ALU_SLT;
          3'b011: w_sel = ALU_SLTU;
          3'b100: w_sel = ALU_XOR;
          3'b101: w_sel = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: w_sel = ALU_OR;
          3'b111: w_sel = ALU_AND;
        endcase
      end
      CLS_MULDIV: begin
        o_isMuldiv = 1'b1;
        case (i_funct3)
          3'b000: w_sel = ALU_MUL;
          3'b001: w_sel = ALU_MULH;
          3'b010: w_sel = ALU_MULHSU;
          3'b011: w_sel = ALU_MULHU;
          3'b100: w_sel = ALU_DIV;
          3'b101: w_sel = ALU_DIVU;
          3'b110: w_sel = ALU_REM;
          3'b111: w_sel = ALU_REMU;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/ex_issue_ctrl.sv
// ---------------------------------------------------------------------------
// ex_issue_ctrl
// Execute-stage issue controller in front of the RV32IM ALU. Accepts one
// decoded instruction per handshake, drives the ALU opcode and operands,
// holds operands steady while a MUL/DIV runs, and registers the result for
// writeback. One operation in flight; single-cycle ops sustain 1 op/cycle.
// Ports:
//   clk, rst                     clock; synchronous active-low reset
//   in_valid/in_ready            decode handshake
//   in_class, in_funct3,
//   in_funct7b5                  decoded operation
//   in_rs1, in_rs2, in_imm       operand sources
//   in_rd                        destination register
//   alu_dataA/B, alu_sel         ALU operands and opcode
//   alu_dataD, alu_ready         ALU result and its valid
//   out_valid/out_ready          writeback handshake
//   out_data, out_rd             registered result and destination
//   out_illegal                  result belongs to an illegal op (data 0)
//   md_timeout                   MUL/DIV abandoned (data DEADBEEF)
// ---------------------------------------------------------------------------
module ex_issue_ctrl
  import ex_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MIN_MD_WAIT = 1,
  parameter int MD_TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_class,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] alu_dataA,
  output logic [XLEN-1:0] alu_dataB,
  output logic [4:0]      alu_sel,
  input  logic [XLEN-1:0] alu_dataD,
  input  logic            alu_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic            md_timeout
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_MD_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(MD_TIMEOUT);

  state_e            r_state;
  state_e            w_stateNext;
  logic [XLEN-1:0]   r_opA;
  logic [XLEN-1:0]   r_opB;
  logic [4:0]        r_sel;
  logic [4:0]        r_pendRd;
  logic [CNT_W-1:0]  r_mdCount;
  logic              r_outValid;
  logic              r_outIllegal;
  logic              r_mdTimeout;
  logic [XLEN-1:0]   r_outData;
  logic [4:0]        r_outRd;

  logic [4:0]        w_decSel;
  logic              w_decMuldiv;
  logic              w_decIllegal;
  logic [XLEN-1:0]   w_opB;
  logic              w_outFree;
  logic              w_accept;
  logic              w_mdReadyOk;
  logic              w_mdTimeoutHit;
  logic              w_mdDone;

  ex_sel_decode u_selDecode (
    .i_class    (in_class),
    .i_funct3   (in_funct3),
    .i_funct7b5 (in_funct7b5),
    .o_sel      (w_decSel),
    .o_isMuldiv (w_decMuldiv),
    .o_illegal  (w_decIllegal)
  );

  // The output register is free when empty or being drained this cycle;
  // new work is only taken in IDLE so a pending result is never overwritten.
  assign w_outFree = !r_outValid || out_ready;
  assign in_ready  = (r_state == IDLE) && w_outFree;
  assign w_accept  = in_valid && in_ready;
  assign w_opB     = (op_class_e'(in_class) == CLS_OPIMM) ? in_imm : in_rs2;

  // r_mdCount is 1 in the first WAIT_MD cycle; ready seen during the first
  // MIN_MD_WAIT cycles may be left over from the previous op and is ignored.
  assign w_mdReadyOk    = alu_ready && (r_mdCount > MIN_WAIT_C);
  assign w_mdTimeoutHit = (MD_TIMEOUT != 0) && (r_mdCount >= TIMEOUT_C);
  assign w_mdDone       = (w_mdReadyOk || w_mdTimeoutHit) && w_outFree;

  // Next-state and ALU drive. The ALU sees the incoming op only when it is
  // actually accepted, the latched op while a MUL/DIV runs, and an all-zero
  // op in DRAIN so the MUL/DIV units observe an opcode change between ops.
  always_comb begin
    w_stateNext = r_state;
    alu_sel     = 5'h00;
    alu_dataA   = '0;
    alu_dataB   = '0;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_decIllegal) begin
          alu_sel   = w_decSel;
          alu_dataA = in_rs1;
          alu_dataB = w_opB;
        end
        if (w_accept && w_decMuldiv) begin
          w_stateNext = WAIT_MD;
        end
      end
      WAIT_MD: begin
        alu_sel   = r_sel;
        alu_dataA = r_opA;
        alu_dataB = r_opB;
        if (w_mdDone) begin
          w_stateNext = DRAIN;
        end
      end
      DRAIN: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // State, operand latch, timeout counter and result register. A reset in
  // WAIT_MD simply drops the op: nothing is ever written to the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_opA        <= '0;
      r_opB        <= '0;
      r_sel        <= 5'h00;
      r_pendRd     <= 5'd0;
      r_mdCount    <= '0;
      r_outValid   <= 1'b0;
      r_outIllegal <= 1'b0;
      r_mdTimeout  <= 1'b0;
      r_outData    <= '0;
      r_outRd      <= 5'd0;
    end else begin
      r_state <= w_stateNext;
      if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_decIllegal) begin
              r_outValid   <= 1'b1;
              r_outIllegal <= 1'b1;
              r_mdTimeout  <= 1'b0;
              r_outData    <= '0;
              r_outRd      <= in_rd;
            end else if (w_decMuldiv) begin
              r_opA     <= in_rs1;
              r_opB     <= w_opB;
              r_sel     <= w_decSel;
              r_pendRd  <= in_rd;
              r_mdCount <= CNT_W'(1);
            end else begin
              r_outValid   <= 1'b1;
              r_outIllegal <= 1'b0;
              r_mdTimeout  <= 1'b0;
              r_outData    <= alu_dataD;
              r_outRd      <= in_rd;
            end
          end
        end
        WAIT_MD: begin
          if (w_mdDone) begin
            r_outValid   <= 1'b1;
            r_outIllegal <= 1'b0;
            r_mdTimeout  <= !w_mdReadyOk;
            r_outData    <= w_mdReadyOk ? alu_dataD : XLEN'(ALU_SEL_DEBUG);
            r_outRd      <= r_pendRd;
          end else if (r_mdCount != {CNT_W{1'b1}}) begin
            r_mdCount <= r_mdCount + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = r_outValid;
  assign out_data    = r_outData;
  assign out_rd      = r_outRd;
  assign out_illegal = r_outIllegal;
  assign md_timeout  = r_mdTimeout;

endmodule
